// File: rtl/j1b_io_uart.sv
// J1B IO-port responder: UART 8N1 TX/RX behind 16-entry FIFOs
// plus a free-running cycle counter, all read back via registered io_din.
module j1b_io_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_LOG2    = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic [15:0] io_addr,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_din,
   output logic        uart_tx,
   input  logic        uart_rx
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int PW    = FIFO_LOG2 + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic sel_data, sel_stat, sel_cyc;
   logic [31:0] rd_val, cycles;
   wire  [31:0] cyc_nxt;
   logic ovr;

   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic [7:0] tx_head;

   uart_state_t tx_state, rx_state;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [2:0] tx_bit, rx_bit;
   logic [7:0] tx_shift, rx_shift;
   logic tx_busy, rx_done, ovr_set;
   logic rx_s1, rx_s2, rx_s3;

   logic unused_bits;
   assign unused_bits = ^{io_addr[15], io_addr[11:0], io_wdata[31:8]};

   // One-hot decode; lower-numbered bit wins when several are set.
   always_comb begin
      sel_data = 1'b0;
      sel_stat = 1'b0;
      sel_cyc  = 1'b0;
      unique case (1'b1)
         io_addr[12]:                              sel_data = 1'b1;
         !io_addr[12] && io_addr[13]:              sel_stat = 1'b1;
         !io_addr[12] && !io_addr[13] && io_addr[14]: sel_cyc = 1'b1;
         default: ;
      endcase
   end

   assign tx_empty = tx_wp == tx_rp;
   assign tx_full  = (tx_wp[FIFO_LOG2] != tx_rp[FIFO_LOG2]) &&
                     (tx_wp[FIFO_LOG2-1:0] == tx_rp[FIFO_LOG2-1:0]);
   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[FIFO_LOG2] != rx_rp[FIFO_LOG2]) &&
                     (rx_wp[FIFO_LOG2-1:0] == rx_rp[FIFO_LOG2-1:0]);
   assign tx_head  = tx_mem[tx_rp[FIFO_LOG2-1:0]];

   assign tx_push = io_wr && sel_data && !tx_full;
   assign tx_pop  = !tx_empty && (tx_state == IDLE ||
                    (tx_state == STOP && tx_cnt == BIT_LAST));
   assign rx_pop  = io_rd && sel_data && !rx_empty;
   assign rx_done = rx_state == STOP && rx_cnt == BIT_LAST;
   assign rx_push = rx_done && rx_s2 && (!rx_full || rx_pop);
   assign ovr_set = rx_done && rx_s2 && rx_full && !rx_pop;
   assign tx_busy = !tx_empty || tx_state != IDLE;
   assign cyc_nxt = cycles + 32'd1;

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel_data: rd_val = rx_empty ? 32'h0 :
                            {24'h0, rx_mem[rx_rp[FIFO_LOG2-1:0]]};
         sel_stat: rd_val = {28'h0, tx_busy, ovr, !rx_empty, !tx_full};
         sel_cyc:  rd_val = cycles;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         io_din <= '0;
         cycles <= '0;
         ovr    <= 1'b0;
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_s1  <= 1'b1;
         rx_s2  <= 1'b1;
         rx_s3  <= 1'b1;
      end else begin
         if (io_rd) io_din <= rd_val;
         cycles <= (io_wr && sel_cyc) ? '0 : cyc_nxt;
         if (tx_push) tx_wp <= tx_wp + PTR_ONE;
         if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
         if (rx_push) rx_wp <= rx_wp + PTR_ONE;
         if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
         if (ovr_set) ovr <= 1'b1;
         else if (io_rd && sel_stat) ovr <= 1'b0;
         {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx};
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[FIFO_LOG2-1:0]] <= io_wdata[7:0];
      if (rx_push) rx_mem[rx_wp[FIFO_LOG2-1:0]] <= rx_shift;
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         unique case (tx_state)
            IDLE: if (tx_pop) begin
               tx_shift <= tx_head;
               tx_cnt   <= '0;
               uart_tx  <= 1'b0;
               tx_state <= START;
            end
            START: if (tx_cnt == BIT_LAST) begin
               tx_cnt   <= '0;
               tx_bit   <= '0;
               uart_tx  <= tx_shift[0];
               tx_state <= DATA;
            end else tx_cnt <= tx_cnt + CNT_ONE;
            DATA: if (tx_cnt == BIT_LAST) begin
               tx_cnt <= '0;
               if (tx_bit == 3'd7) begin
                  uart_tx  <= 1'b1;
                  tx_state <= STOP;
               end else begin
                  tx_bit   <= tx_bit + 3'd1;
                  uart_tx  <= tx_shift[1];
                  tx_shift <= {1'b0, tx_shift[7:1]};
               end
            end else tx_cnt <= tx_cnt + CNT_ONE;
            // Chain straight into the next start bit when more is queued.
            STOP: if (tx_cnt == BIT_LAST) begin
               tx_cnt <= '0;
               if (tx_pop) begin
                  tx_shift <= tx_head;
                  uart_tx  <= 1'b0;
                  tx_state <= START;
               end else tx_state <= IDLE;
            end else tx_cnt <= tx_cnt + CNT_ONE;
            default: tx_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         unique case (rx_state)
            IDLE: if (rx_s3 && !rx_s2) begin
               rx_cnt   <= '0;
               rx_state <= START;
            end
            START: if (rx_cnt == HALF_LAST) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_s2 ? IDLE : DATA;
            end else rx_cnt <= rx_cnt + CNT_ONE;
            DATA: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_s2, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state <= STOP;
               else rx_bit <= rx_bit + 3'd1;
            end else rx_cnt <= rx_cnt + CNT_ONE;
            STOP: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               rx_state <= IDLE;
            end else rx_cnt <= rx_cnt + CNT_ONE;
            default: rx_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_j1b_io_uart.sv
// Directed bench for j1b_io_uart: bus reads, TX frame monitor
// and RX driver, all compared through expectation queues.
module tb_j1b_io_uart;
   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        resetq;
   logic [15:0] io_addr;
   logic        io_rd, io_wr;
   logic [31:0] io_wdata;
   logic [31:0] io_din;
   logic        uart_tx;
   logic        uart_rx;

   always #5 clk = ~clk;

   j1b_io_uart #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(4)) dut (
      .clk(clk), .resetq(resetq), .io_addr(io_addr),
      .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata),
      .io_din(io_din), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   int compared = 0;
   int mismatched = 0;
   logic [31:0] rd_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_model[$];
   bit ovr_model = 1'b0;
   bit mon_busy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] st_exp();
      logic [31:0] v;
      v = {28'h0, 1'b0, ovr_model, rx_model.size() != 0, 1'b1};
      ovr_model = 1'b0;
      return v;
   endfunction

   function automatic logic [31:0] data_exp();
      if (rx_model.size() == 0) return 32'h0;
      return {24'h0, rx_model.pop_front()};
   endfunction

   task automatic bus_read(input logic [15:0] a, input logic [31:0] exp,
                           input string tag, input bit wr = 1'b0);
      io_addr = a; io_rd = 1'b1; io_wr = wr; io_wdata = '0;
      rd_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      io_rd = 1'b0; io_wr = 1'b0;
      check(tag, io_din, rd_q.pop_front());
   endtask

   task automatic bus_read_raw(input logic [15:0] a, output logic [31:0] d);
      io_addr = a; io_rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      io_rd = 1'b0;
      d = io_din;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      io_addr = a; io_wr = 1'b1; io_wdata = d;
      @(negedge clk);
      io_wr = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         uart_rx = f[b];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      if (stop) begin
         if (rx_model.size() < 16) rx_model.push_back(d);
         else ovr_model = 1'b1;
      end
   endtask

   task automatic wait_tx_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         done = (tx_q.size() == 0) && !mon_busy;
      end
      check(tag, {31'h0, done}, 32'h1);
   endtask

   // Serial monitor: sample every bit period, check framing, pop expected.
   initial begin
      logic [9:0] frame;
      logic [31:0] exp;
      bit stable;
      forever begin
         @(negedge clk);
         if (resetq === 1'b1 && uart_tx === 1'b0) begin
            mon_busy = 1'b1;
            stable = 1'b1;
            for (int b = 0; b < 10; b++)
               for (int s = 0; s < CPB; s++) begin
                  if (b != 0 || s != 0) @(negedge clk);
                  if (s == 0) frame[b] = uart_tx;
                  else if (uart_tx !== frame[b]) stable = 1'b0;
               end
            exp = tx_q.size() != 0 ? {24'h0, tx_q.pop_front()} : 32'hFFFF_FFFF;
            check("tx_frame", {29'h0, stable, frame[9], frame[0]}, 32'h6);
            check("tx_byte", {24'h0, frame[8:1]}, exp);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] st;
      int n;
      resetq = 1'b0; io_addr = '0; io_rd = 1'b0; io_wr = 1'b0;
      io_wdata = '0; uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_io_din", io_din, 32'h0);
      check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
      resetq = 1'b1;
      bus_read(16'h2000, 32'h1, "rst_status");
      bus_read(16'h4000, 32'h1, "rst_cycles");

      // Single byte: busy holds through pop cycle, 10 bit times, read latency.
      tx_q.push_back(8'hA5);
      bus_write(16'h1000, 32'h0000_00A5);
      n = 0;
      do begin
         bus_read_raw(16'h2000, st);
         n++;
      end while (st[3] && n < 100);
      check("tx_busy_len", n, 2 + 10 * CPB);
      wait_tx_idle("tx_drain_a5");

      // 16 in the FIFO plus one already in the shifter; the 18th is dropped.
      for (int i = 0; i < 17; i++) begin
         tx_q.push_back(8'(i));
         bus_write(16'h1000, 32'(i));
      end
      bus_read(16'h2000, 32'h8, "tx_full_status");
      bus_write(16'h1000, 32'h11);
      bus_read(16'h2000, 32'h8, "tx_full_status2");
      wait_tx_idle("tx_drain_full");
      repeat (10 * CPB + 10) @(negedge clk);
      bus_read(16'h2000, 32'h1, "tx_idle_status");

      send_rx(8'h3C, 1'b1);
      bus_read(16'h2000, st_exp(), "rx_status");
      bus_read(16'h1000, data_exp(), "rx_data");
      bus_read(16'h1000, data_exp(), "rx_empty_read");
      bus_read(16'h2000, st_exp(), "rx_status_clr");

      for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1);
      bus_read(16'h2000, st_exp(), "ovr_status");
      bus_read(16'h2000, st_exp(), "ovr_cleared");
      for (int i = 0; i < 16; i++) bus_read(16'h1000, data_exp(), "ovr_data");
      bus_read(16'h1000, data_exp(), "ovr_drained");

      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      bus_read(16'h2000, st_exp(), "glitch_status");
      send_rx(8'h55, 1'b0);
      bus_read(16'h2000, st_exp(), "frame_err_status");
      send_rx(8'h81, 1'b1);
      bus_read(16'h1000, data_exp(), "rx_recover");

      bus_read(16'h0000, 32'h0, "no_select");
      bus_read(16'h6000, st_exp(), "stat_over_cyc");

      bus_write(16'h4000, 32'h0);
      repeat (10) @(negedge clk);
      bus_read(16'h4000, 32'd10, "cyc_10_rw", 1'b1);
      bus_read(16'h4000, 32'd0, "cyc_after_rw");

      force dut.cyc_nxt = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 release dut.cyc_nxt;
      @(negedge clk);
      bus_read(16'h4000, 32'hFFFF_FFFF, "cyc_max");
      bus_read(16'h4000, 32'h0, "cyc_wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
